// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - command sequencer for an 8-bit load/shift-right register
//
// Purpose:
//   Takes one command at a time (operand, shift amount, logical/arithmetic mode).
//   It drives the external shifter through one load cycle and then N shift cycles.
//   It then captures the shifter output and pulses done for one cycle.
//
// Ports:
//   clk           system clock, shared with the shifter
//   reset         asynchronous active-high reset
//   start         command request, sampled only in IDLE
//   value         operand to load
//   amount        requested right-shift count (saturates at WIDTH)
//   arith         1 = arithmetic shift right, 0 = logical
//   abort         cancel the operation in flight (wins over start in IDLE)
//   shf_q         shifter register output
//   shf_load_val  shifter LoadVal (latched operand)
//   shf_load_n    shifter Load_n, active low
//   shf_shift     shifter ShiftRight
//   shf_asr       shifter ASR
//   busy          high in LOAD, SHIFT and CAPTURE
//   done          one-cycle completion pulse, coincident with IDLE
//   result        captured shifter value, held until the next done

module shift_sequencer #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] value,
   input  logic [AMT_W-1:0] amount,
   input  logic             arith,
   input  logic             abort,
   input  logic [WIDTH-1:0] shf_q,
   output logic [WIDTH-1:0] shf_load_val,
   output logic             shf_load_n,
   output logic             shf_shift,
   output logic             shf_asr,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      SHIFT   = 2'd2,
      CAPTURE = 2'd3
   } state_t;

   localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);
   localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);

   state_t           state, state_nxt;
   logic [AMT_W-1:0] count, count_nxt;
   logic [WIDTH-1:0] value_q, value_nxt;
   logic             arith_q, arith_nxt;
   logic [WIDTH-1:0] result_nxt;
   logic             done_nxt;
   logic [AMT_W-1:0] amt_sat;

   // Shifting further than WIDTH cannot change the result any more.
   assign amt_sat = (amount > AMT_MAX) ? AMT_MAX : amount;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         count   <= '0;
         value_q <= '0;
         arith_q <= 1'b0;
         result  <= '0;
         done    <= 1'b0;
      end else begin
         state   <= state_nxt;
         count   <= count_nxt;
         value_q <= value_nxt;
         arith_q <= arith_nxt;
         result  <= result_nxt;
         done    <= done_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      count_nxt  = count;
      value_nxt  = value_q;
      arith_nxt  = arith_q;
      result_nxt = result;
      done_nxt   = 1'b0;

      case (state)
         IDLE: begin
            if (start && !abort) begin
               value_nxt = value;
               arith_nxt = arith;
               count_nxt = amt_sat;
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            if (abort)
               state_nxt = IDLE;
            else if (count != '0)
               state_nxt = SHIFT;
            else
               state_nxt = CAPTURE;
         end
         SHIFT: begin
            if (abort) begin
               state_nxt = IDLE;
            end else begin
               count_nxt = count - AMT_ONE;
               // The last shift cycle is the one entered with count == 1.
               if (count == AMT_ONE)
                  state_nxt = CAPTURE;
            end
         end
         CAPTURE: begin
            state_nxt = IDLE;
            if (!abort) begin
               result_nxt = shf_q;
               done_nxt   = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The shifter controls are decoded from registered state only.
   // The operand stays on LoadVal for the whole operation because the shifter
   // takes its ASR fill bit from LoadVal[MSB].
   always_comb begin
      shf_load_val = value_q;
      shf_load_n   = (state != LOAD);
      shf_shift    = (state == SHIFT);
      shf_asr      = (state == SHIFT) && arith_q;
      busy         = (state != IDLE);
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed self-checking bench for shift_sequencer

module tb_shift_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] value;
   logic [3:0] amount;
   logic       arith;
   logic       abort;
   logic [7:0] shf_q = 8'h00;
   logic [7:0] shf_load_val;
   logic       shf_load_n;
   logic       shf_shift;
   logic       shf_asr;
   logic       busy;
   logic       done;
   logic [7:0] result;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   shift_sequencer #(.WIDTH(8), .AMT_W(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .value        (value),
      .amount       (amount),
      .arith        (arith),
      .abort        (abort),
      .shf_q        (shf_q),
      .shf_load_val (shf_load_val),
      .shf_load_n   (shf_load_n),
      .shf_shift    (shf_shift),
      .shf_asr      (shf_asr),
      .busy         (busy),
      .done         (done),
      .result       (result)
   );

   // Behavioural model of the load/shift-right register; ASR fill is LoadVal[MSB].
   always_ff @(posedge clk) begin
      if (!shf_load_n)
         shf_q <= shf_load_val;
      else if (shf_shift)
         shf_q <= {(shf_asr ? shf_load_val[7] : 1'b0), shf_q[7:1]};
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Drive a command at a falling edge; returns at the falling edge after the accept edge.
   task automatic issue(input logic [7:0] v, input logic [3:0] a, input logic ar);
      @(negedge clk);
      start  = 1'b1;
      value  = v;
      amount = a;
      arith  = ar;
      @(negedge clk);
      start  = 1'b0;
   endtask

   // Edges are counted with the accept edge as edge 1.
   // Returns at the falling edge where done is seen, or when the bound runs out.
   task automatic wait_done(output int edges, output int busy_c, output int shift_c);
      edges   = 1;
      busy_c  = 0;
      shift_c = 0;
      while (!done && edges < 40) begin
         if (busy)      busy_c++;
         if (shf_shift) shift_c++;
         @(negedge clk);
         edges++;
      end
   endtask

   task automatic run_cmd(input string tag, input logic [7:0] v, input logic [3:0] a,
                          input logic ar, input logic [7:0] exp_res, input int exp_shifts);
      int e, b, s;
      issue(v, a, ar);
      wait_done(e, b, s);
      check({tag, "_done"},    32'(done), 32'd1);
      check({tag, "_latency"}, 32'(e), 32'(exp_shifts + 3));
      check({tag, "_busy"},    32'(b), 32'(exp_shifts + 2));
      check({tag, "_shifts"},  32'(s), 32'(exp_shifts));
      check({tag, "_result"},  32'(result), 32'(exp_res));
      check({tag, "_idle"},    32'(busy), 32'd0);
      @(negedge clk);
      check({tag, "_pulse"},   32'(done), 32'd0);
   endtask

   initial begin
      int e, b, s;
      reset  = 1'b1;
      start  = 1'b0;
      value  = 8'h00;
      amount = 4'd0;
      arith  = 1'b0;
      abort  = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);

      check("rst_busy",   32'(busy), 32'd0);
      check("rst_done",   32'(done), 32'd0);
      check("rst_load_n", 32'(shf_load_n), 32'd1);
      check("rst_shift",  32'(shf_shift), 32'd0);
      check("rst_asr",    32'(shf_asr), 32'd0);
      check("rst_ldval",  32'(shf_load_val), 32'h00);
      check("rst_result", 32'(result), 32'h00);

      run_cmd("lsr_b4_2", 8'hB4, 4'd2,  1'b0, 8'h2D, 2);
      run_cmd("asr_b4_2", 8'hB4, 4'd2,  1'b1, 8'hED, 2);
      run_cmd("asr_sat",  8'h80, 4'd12, 1'b1, 8'hFF, 8);
      run_cmd("lsr_sat",  8'hA5, 4'd15, 1'b0, 8'h00, 8);
      run_cmd("zero_amt", 8'h5A, 4'd0,  1'b0, 8'h5A, 0);

      // A start pulse during SHIFT must be ignored.
      issue(8'hF0, 4'd4, 1'b0);
      check("load_phase_n", 32'(shf_load_n), 32'd0);
      check("load_val",     32'(shf_load_val), 32'hF0);
      @(negedge clk);
      @(negedge clk);
      check("shift_phase",  32'(shf_shift), 32'd1);
      start  = 1'b1;
      value  = 8'h01;
      amount = 4'd0;
      @(negedge clk);
      start  = 1'b0;
      wait_done(e, b, s);
      check("ign_done",   32'(done), 32'd1);
      check("ign_result", 32'(result), 32'h0F);

      // A start in the done cycle is accepted.
      start  = 1'b1;
      value  = 8'h33;
      amount = 4'd1;
      arith  = 1'b0;
      @(negedge clk);
      start  = 1'b0;
      check("b2b_busy",   32'(busy), 32'd1);
      check("b2b_load_n", 32'(shf_load_n), 32'd0);
      wait_done(e, b, s);
      check("b2b_latency", 32'(e), 32'd4);
      check("b2b_result",  32'(result), 32'h19);
      @(negedge clk);

      // Abort in the second shift cycle of a 6-shift command.
      issue(8'h77, 4'd6, 1'b1);
      @(negedge clk);
      @(negedge clk);
      check("abort_in_shift", 32'(shf_shift), 32'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy",  32'(busy), 32'd0);
      check("abort_done",  32'(done), 32'd0);
      check("abort_shift", 32'(shf_shift), 32'd0);
      check("abort_asr",   32'(shf_asr), 32'd0);
      s = 0;
      for (int i = 0; i < 10; i++) begin
         if (done) s++;
         @(negedge clk);
      end
      check("abort_no_done", 32'(s), 32'd0);
      check("abort_result",  32'(result), 32'h19);

      // Abort together with start in IDLE: no accept.
      start = 1'b1;
      abort = 1'b1;
      value = 8'hAA;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check("abort_start_busy", 32'(busy), 32'd0);
      @(negedge clk);
      check("abort_start_busy2", 32'(busy), 32'd0);

      // Reset asserted mid-SHIFT takes effect without waiting for a clock edge.
      issue(8'hC3, 4'd5, 1'b1);
      @(negedge clk);
      @(negedge clk);
      check("mid_asr", 32'(shf_asr), 32'd1);
      #1 reset = 1'b1;
      #1;
      check("arst_busy",   32'(busy), 32'd0);
      check("arst_shift",  32'(shf_shift), 32'd0);
      check("arst_asr",    32'(shf_asr), 32'd0);
      check("arst_load_n", 32'(shf_load_n), 32'd1);
      check("arst_ldval",  32'(shf_load_val), 32'h00);
      check("arst_result", 32'(result), 32'h00);
      check("arst_done",   32'(done), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      run_cmd("post_rst", 8'h96, 4'd3, 1'b1, 8'hF2, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
